// File: rtl/sseg_scan_ctrl_pkg.sv
// Shared types and constants for the seven-segment scan controller.
package sseg_pkg;

  typedef enum logic {
    BLANK = 1'b0,
    ON    = 1'b1
  } scan_state_t;

  localparam logic [7:0]  SEG_OFF    = 8'hFF;
  localparam logic [3:0]  ANODE_OFF  = 4'hF;
  localparam int unsigned NUM_DIGITS = 4;

  function automatic logic [3:0] anode_sel(input logic [1:0] idx);
    return ~(4'b0001 << idx);
  endfunction

endpackage

// File: rtl/sseg_scan_ctrl_if.sv
// Frame load port: producer offers a 4-digit pattern, controller accepts on valid&&ready.
interface sseg_scan_ctrl_if;
  logic [31:0] seg_data;
  logic        load_valid;
  logic        load_ready;

  modport master (output seg_data, output load_valid, input  load_ready);
  modport slave  (input  seg_data, input  load_valid, output load_ready);
endinterface

// File: rtl/sseg_slot_timer.sv
// Blank/dwell phase counter; pulses at the last cycle of each phase and tracks the digit index.
module sseg_slot_timer #(
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       on_phase,
  output logic       blank_done,
  output logic       dwell_done,
  output logic [1:0] idx
);

  localparam int unsigned DW_W = $clog2(DWELL_CYCLES);
  localparam int unsigned BL_W = $clog2(BLANK_CYCLES);
  localparam int unsigned MX_W = (DW_W > BL_W) ? DW_W : BL_W;
  localparam int unsigned CW   = (MX_W > 0) ? MX_W : 1;

  localparam logic [CW-1:0] DWELL_LAST = CW'(DWELL_CYCLES - 1);
  localparam logic [CW-1:0] BLANK_LAST = CW'(BLANK_CYCLES - 1);

  logic [CW-1:0] cnt;

  assign blank_done = !on_phase && (cnt == BLANK_LAST);
  assign dwell_done =  on_phase && (cnt == DWELL_LAST);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      cnt <= '0;
      idx <= '0;
    end else begin
      if (blank_done || dwell_done) cnt <= '0;
      else                          cnt <= cnt + 1'b1;
      if (dwell_done) idx <= idx + 2'd1;
    end
  end

endmodule

// File: rtl/sseg_scan_ctrl.sv
// Four-digit multiplexed seven-segment scanner with blanking gaps, PWM brightness
// and frame-atomic pattern updates.
module sseg_scan_ctrl
  import sseg_pkg::*;
#(
  parameter int unsigned DWELL_CYCLES = 100000,
  parameter int unsigned BLANK_CYCLES = 1000,
  parameter int unsigned BRIGHT_W     = 4
) (
  input  logic                clk,
  input  logic                rst_n,
  sseg_scan_ctrl_if.slave     ld,
  input  logic [BRIGHT_W-1:0] brightness,
  input  logic [3:0]          digit_en,
  output logic                frame_start,
  output logic [3:0]          anode,
  output logic [7:0]          cathodes
);

  if (DWELL_CYCLES == 0 || BLANK_CYCLES == 0) begin : g_bad_params
    $error("sseg_scan_ctrl: DWELL_CYCLES and BLANK_CYCLES must be >= 1");
  end

  scan_state_t         state;
  logic                blank_done;
  logic                dwell_done;
  logic [1:0]          idx;
  logic [BRIGHT_W-1:0] pwm_cnt;
  logic [BRIGHT_W-1:0] bright_lat;
  logic [3:0]          en_lat;
  logic [31:0]         active;
  logic [31:0]         pending;
  logic                pending_vld;
  logic                shown;
  logic                xfer;
  logic                boundary;
  logic                lit;

  sseg_slot_timer #(
    .DWELL_CYCLES (DWELL_CYCLES),
    .BLANK_CYCLES (BLANK_CYCLES)
  ) u_timer (
    .clk        (clk),
    .rst_n      (rst_n),
    .on_phase   (state == ON),
    .blank_done (blank_done),
    .dwell_done (dwell_done),
    .idx        (idx)
  );

  assign xfer     = ld.load_valid && ld.load_ready;
  assign boundary = dwell_done && (idx == 2'(NUM_DIGITS - 1));
  // shown keeps the anodes dark after reset until a real pattern has been applied
  assign lit      = (state == ON) && shown && en_lat[idx] && (pwm_cnt <= bright_lat);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state         <= BLANK;
      pwm_cnt       <= '0;
      bright_lat    <= '1;
      en_lat        <= 4'hF;
      active        <= '1;
      pending       <= '1;
      pending_vld   <= 1'b0;
      shown         <= 1'b0;
      ld.load_ready <= 1'b1;
      frame_start   <= 1'b0;
      anode         <= ANODE_OFF;
      cathodes      <= SEG_OFF;
    end else begin
      case (state)
        BLANK: if (blank_done) state <= ON;
        ON:    if (dwell_done) state <= BLANK;
      endcase
      if (state == ON) pwm_cnt <= pwm_cnt + 1'b1;

      frame_start <= boundary;
      if (boundary) begin
        bright_lat <= brightness;
        en_lat     <= digit_en;
        if (pending_vld) begin
          active      <= pending;
          shown       <= 1'b1;
          pending_vld <= 1'b0;
        end
      end
      // a capture coinciding with the boundary waits for the next one
      if (xfer) begin
        pending     <= ld.seg_data;
        pending_vld <= 1'b1;
      end
      ld.load_ready <= xfer ? 1'b0 : !pending_vld;

      if (lit) begin
        anode    <= anode_sel(idx);
        cathodes <= active[{idx, 3'b000} +: 8];
      end else begin
        anode    <= ANODE_OFF;
        cathodes <= SEG_OFF;
      end
    end
  end

endmodule

// File: tb/tb_sseg_scan_ctrl.sv
// Randomized bench for sseg_scan_ctrl against a frame/slot arithmetic reference model.
module tb_sseg_scan_ctrl;

  localparam int unsigned DW      = 8;
  localparam int unsigned BL      = 2;
  localparam int unsigned BW      = 4;
  localparam int unsigned SLOT    = DW + BL;
  localparam int unsigned FRAME   = 4 * SLOT;
  localparam int unsigned PWM_MOD = 1 << BW;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [BW-1:0] brightness;
  logic [3:0]    digit_en;
  logic          frame_start;
  logic [3:0]    anode;
  logic [7:0]    cathodes;

  sseg_scan_ctrl_if ld ();

  sseg_scan_ctrl #(
    .DWELL_CYCLES (DW),
    .BLANK_CYCLES (BL),
    .BRIGHT_W     (BW)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .ld          (ld),
    .brightness  (brightness),
    .digit_en    (digit_en),
    .frame_start (frame_start),
    .anode       (anode),
    .cathodes    (cathodes)
  );

  always #5 clk = ~clk;

  int unsigned checks = 0;
  int unsigned errors = 0;

  // reference model: k counts clock edges since reset release
  int unsigned   k;
  logic [31:0]   m_active;
  logic [31:0]   m_pend_data;
  bit            m_shown;
  bit            m_pend;
  bit            m_ready;
  logic [BW-1:0] m_bright;
  logic [3:0]    m_en;
  bit            m_last_xfer;
  int unsigned   fs_seen;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    assert (obs === exp_v) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp_v);
    end
  endtask

  task automatic model_reset();
    k = 0;
    m_active = '1;
    m_pend_data = '1;
    m_shown = 1'b0;
    m_pend = 1'b0;
    m_ready = 1'b1;
    m_bright = '1;
    m_en = 4'hF;
    m_last_xfer = 1'b0;
  endtask

  // One clock edge: predict from pre-edge inputs/model, then compare just after the edge.
  task automatic cycle();
    int unsigned   p    = k % FRAME;
    int unsigned   slot = p / SLOT;
    int unsigned   w    = p % SLOT;
    bit            on   = (w >= BL);
    int unsigned   pwm  = 0;
    logic [3:0]    ea   = 4'hF;
    logic [7:0]    ec   = 8'hFF;
    bit            efs  = (p == FRAME - 1);
    bit            xfer = ld.load_valid && m_ready;
    logic [31:0]   din  = ld.seg_data;
    logic [BW-1:0] b_in = brightness;
    logic [3:0]    e_in = digit_en;
    bit            applied = 1'b0;
    if (on) pwm = ((k / FRAME) * 4 * DW + slot * DW + (w - BL)) % PWM_MOD;
    if (on && m_shown && m_en[slot] && pwm <= int'(m_bright)) begin
      ea = ~(4'b0001 << slot);
      ec = m_active[slot*8 +: 8];
    end
    @(posedge clk);
    #1;
    if (efs) begin
      if (m_pend) begin
        m_active = m_pend_data;
        m_shown  = 1'b1;
        m_pend   = 1'b0;
        applied  = 1'b1;
      end
      m_bright = b_in;
      m_en     = e_in;
    end
    if (xfer) begin
      m_pend      = 1'b1;
      m_pend_data = din;
    end
    m_ready = !m_pend && !applied;
    m_last_xfer = xfer;
    k++;
    if (frame_start === 1'b1) fs_seen++;
    chk("anode", 32'(anode), 32'(ea));
    chk("cathodes", 32'(cathodes), 32'(ec));
    chk("frame_start", 32'(frame_start), 32'(efs));
    chk("load_ready", 32'(ld.load_ready), 32'(m_ready));
  endtask

  task automatic run(input int unsigned n);
    for (int unsigned i = 0; i < n; i++) cycle();
  endtask

  initial begin
    rst_n = 1'b0;
    ld.load_valid = 1'b0;
    ld.seg_data = '0;
    brightness = 4'hF;
    digit_en = 4'hF;
    repeat (3) @(posedge clk);
    #1;
    chk("rst_anode", 32'(anode), 32'h0000_000F);
    chk("rst_cathodes", 32'(cathodes), 32'h0000_00FF);
    chk("rst_ready", 32'(ld.load_ready), 32'h1);
    chk("rst_fs", 32'(frame_start), 32'h0);
    rst_n = 1'b1;
    model_reset();

    // idle with random brightness/enables: stays dark, frame_start every FRAME edges
    fs_seen = 0;
    for (int unsigned i = 0; i < 85; i++) begin
      if (i % 10 == 3) begin
        brightness = BW'($urandom_range(0, PWM_MOD - 1));
        digit_en   = 4'($urandom_range(0, 15));
      end
      cycle();
    end
    chk("idle_fs_count", fs_seen, 32'd2);

    // first pattern, full brightness
    brightness = 4'hF;
    digit_en = 4'hF;
    ld.seg_data = 32'hC0F9A4B0;
    ld.load_valid = 1'b1;
    cycle();
    ld.load_valid = 1'b0;
    ld.seg_data = $urandom;
    run(95);

    // back-to-back loads: second offer held until ready returns
    ld.seg_data = $urandom;
    ld.load_valid = 1'b1;
    for (int unsigned i = 0; i < 150; i++) begin
      cycle();
      if (m_last_xfer) begin
        if (ld.seg_data[0]) ld.load_valid = 1'b0;
        ld.seg_data = {$urandom} | 32'h1;
      end
    end
    ld.load_valid = 1'b0;
    run(45);

    // reduced brightness, sparse enables, then a mid-frame change
    brightness = 4'd3;
    digit_en = 4'b0101;
    run(90);
    for (int unsigned i = 0; i < 60 && (k % FRAME) != 15; i++) cycle();
    brightness = BW'($urandom_range(0, PWM_MOD - 1));
    digit_en = 4'($urandom_range(0, 15));
    run(90);

    // transfer coincident with a frame boundary
    for (int unsigned i = 0; i < 200 && !(m_ready && (k % FRAME) == FRAME - 1); i++) cycle();
    chk("wait_boundary", 32'(m_ready && (k % FRAME) == FRAME - 1), 32'h1);
    brightness = 4'hF;
    digit_en = 4'hF;
    ld.seg_data = $urandom;
    ld.load_valid = 1'b1;
    cycle();
    ld.load_valid = 1'b0;
    run(90);

    // random traffic
    for (int unsigned i = 0; i < 400; i++) begin
      ld.load_valid = ($urandom_range(0, 3) == 0);
      ld.seg_data = $urandom;
      if ($urandom_range(0, 15) == 0) begin
        brightness = BW'($urandom_range(0, PWM_MOD - 1));
        digit_en = 4'($urandom_range(0, 15));
      end
      cycle();
    end
    ld.load_valid = 1'b0;

    // reset in the middle of digit 2's ON phase
    brightness = 4'hF;
    digit_en = 4'hF;
    for (int unsigned i = 0; i < 200 && !(m_shown && (k % FRAME) == 2 * SLOT + 5); i++) cycle();
    chk("wait_digit2_on", 32'(m_shown && (k % FRAME) == 2 * SLOT + 5), 32'h1);
    cycle();
    #3;
    rst_n = 1'b0;
    #1;
    chk("async_rst_anode", 32'(anode), 32'h0000_000F);
    chk("async_rst_cathodes", 32'(cathodes), 32'h0000_00FF);
    chk("async_rst_ready", 32'(ld.load_ready), 32'h1);
    chk("async_rst_fs", 32'(frame_start), 32'h0);
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    model_reset();
    fs_seen = 0;
    run(90);
    chk("post_rst_fs_count", fs_seen, 32'd2);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
